scan_chain_loader: RTL and testbench
====================================

// Module: scan_chain_loader
// PURPOSE
//  Host-side driver for the qtcore scan chain: loads a full chain image
//  (state register, PC, ACC, IR, memory) serially via scan_in and returns the
//  previous image captured from scan_out in the same pass. Gates
//  processor_enable so the core is frozen while shifting, then optionally
//  releases it to run and watches processor_halted.
// PARAMETERS
//  CHAIN_LEN  24  total scan-chain length in bits (2..64)
//  CNT_W      6   shift counter width; must satisfy 2**CNT_W >= CHAIN_LEN
// PORTS
//  clk               in   1          system clock; same clock as the core
//  rst               in   1          synchronous, active-low reset
//  cmd_valid         in   1          host command valid
//  cmd_ready         out  1          loader can accept a command
//  cmd_wdata         in   CHAIN_LEN  image to shift in; bit 0 shifted first
//  cmd_run           in   1          1: enable core after load; 0: stay frozen
//  rsp_valid         out  1          captured image valid
//  rsp_ready         in   1          host accepts rsp_rdata
//  rsp_rdata         out  CHAIN_LEN  previous image; bit 0 = first bit out
//  processor_enable  out  1          to core enable
//  scan_enable       out  1          to core scan_enable
//  scan_in           out  1          to core scan_in
//  scan_out          in   1          from core scan_out (end of chain)
//  processor_halted  in   1          from core control unit
//  halted            out  1          sticky: core reached HALT while running
// BEHAVIOUR
//  - States: IDLE, PAUSE, SHIFT, RESP, RUN. Reset (rst==0 at posedge) forces
//    IDLE, count=0, halted=0, rsp_rdata=0; all outputs 0 except cmd_ready=1.
//    Reset mid-SHIFT aborts: scan_enable drops the next cycle, no response.
//  - cmd_ready=1 in IDLE and RUN only. Handshake = cmd_valid & cmd_ready at
//    posedge; cmd_wdata/cmd_run registered then; host may change them after.
//  - IDLE/RUN --accept--> PAUSE: 1 cycle, processor_enable=0, scan_enable=0
//    (core observes enable low before chain moves). halted cleared on accept.
//  - PAUSE -> SHIFT: exactly CHAIN_LEN cycles with scan_enable=1,
//    processor_enable=0. Shift cycle i (0..CHAIN_LEN-1): scan_in=wdata[i];
//    scan_out sampled at end of cycle i into rdata[i]. count runs 0..LEN-1;
//    on count==CHAIN_LEN-1 go RESP. No count wrap; scan_enable never high
//    for more than CHAIN_LEN consecutive cycles.
//  - RESP: scan_enable=0, processor_enable=0, rsp_valid=1, rsp_rdata stable
//    until rsp_valid & rsp_ready at posedge; then RUN if cmd_run else IDLE.
//    Latency accept->rsp_valid = CHAIN_LEN+1 cycles.
//  - RUN: processor_enable=1, scan_enable=0. If processor_halted==1 at
//    posedge: halted<=1, go IDLE (enable low next cycle). If a command is
//    accepted in the same cycle as processor_halted, the command wins (PAUSE)
//    and halted stays 0.
//  - scan_in=0 whenever scan_enable=0. All outputs registered except
//    cmd_ready/rsp_valid, which decode from the state register only.
//  - rsp_rdata holds last capture until next shift overwrites it.
// TESTING (bench models core chain as CHAIN_LEN-bit shift register)
//  1 Reset: rst=0 3 cycles -> cmd_ready=1, processor_enable=0, scan_enable=0,
//    halted=0, rsp_valid=0.
//  2 Load CHAIN_LEN=24, chain preset 0xA5A5A5, cmd_wdata=0x123456, run=0 ->
//    scan_enable high exactly 24 cycles, rsp_valid on cycle 25,
//    rsp_rdata=0xA5A5A5, model chain=0x123456, processor_enable stays 0.
//  3 Back-to-back: second load 0x000FFF right after response -> rsp_rdata=
//    0x123456; rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable.
//  4 run=1 load, model asserts processor_halted 10 cycles after RUN ->
//    processor_enable high 10 cycles then 0, halted=1, cmd_ready=1.
//  5 Reset asserted at shift cycle 7 -> next cycle scan_enable=0, IDLE,
//    rsp_valid never asserts; subsequent load completes normally.
//  6 In RUN, cmd_valid and processor_halted same cycle -> PAUSE entered,
//    halted=0, processor_enable=0 next cycle.

Source files
------------

// File: rtl/scan_chain_loader.sv
// scan_chain_loader: shifts a full image into the qtcore scan chain and captures the displaced one,
// keeping the core frozen while the chain moves and optionally releasing it to run until HALT.
module scan_chain_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CHAIN_LEN-1:0] cmd_wdata,
    input  logic                 cmd_run,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_rdata,
    output logic                 processor_enable,
    output logic                 scan_enable,
    output logic                 scan_in,
    input  logic                 scan_out,
    input  logic                 processor_halted,
    output logic                 halted
);
    typedef enum logic [2:0] {IDLE, PAUSE, SHIFT, RESP, RUN} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CHAIN_LEN-1:0] sh, sh_n, rdata_n;
    logic run_q, run_n, halted_n, accept, last;
    assign cmd_ready = (state == IDLE) || (state == RUN);
    assign rsp_valid = state == RESP;
    assign accept    = cmd_valid && cmd_ready;
    assign last      = count == CNT_W'(CHAIN_LEN - 1);
    always_comb begin
        state_n  = state;
        count_n  = count;
        sh_n     = sh;
        rdata_n  = rsp_rdata;
        run_n    = run_q;
        halted_n = halted;
        if (accept) begin
            state_n  = PAUSE;
            sh_n     = cmd_wdata;
            run_n    = cmd_run;
            halted_n = 1'b0;
        end else if (state == RUN && processor_halted) begin
            state_n  = IDLE;
            halted_n = 1'b1;
        end
        if (state == PAUSE) begin
            state_n = SHIFT;
            count_n = '0;
        end
        if (state == SHIFT) begin
            rdata_n = {scan_out, rsp_rdata[CHAIN_LEN-1:1]};
            count_n = last ? '0 : count + 1'b1;
            state_n = last ? RESP : SHIFT;
        end
        if (state == RESP && rsp_ready)
            state_n = run_q ? RUN : IDLE;
        // outgoing image shifts out LSB first, one bit per scan cycle
        if (state_n == SHIFT && state != IDLE && state != RUN)
            sh_n = sh >> 1;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            count            <= '0;
            sh               <= '0;
            rsp_rdata        <= '0;
            run_q            <= 1'b0;
            halted           <= 1'b0;
            processor_enable <= 1'b0;
            scan_enable      <= 1'b0;
            scan_in          <= 1'b0;
        end else begin
            state            <= state_n;
            count            <= count_n;
            sh               <= sh_n;
            rsp_rdata        <= rdata_n;
            run_q            <= run_n;
            halted           <= halted_n;
            processor_enable <= state_n == RUN;
            scan_enable      <= state_n == SHIFT;
            scan_in          <= (state_n == SHIFT) && sh[0];
        end
    end
endmodule

// File: tb/tb_scan_chain_loader.sv
// tb_scan_chain_loader: random and directed loads against a simple chain/image model
// of the core; expected responses come from the image the chain held before each load.
module tb_scan_chain_loader;
    localparam int L = 24;
    logic clk = 1'b0, rst = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_run = 1'b0;
    logic [L-1:0] cmd_wdata = '0, rsp_rdata;
    logic rsp_valid, rsp_ready = 1'b0;
    logic processor_enable, scan_enable, scan_in, scan_out, halted;
    logic processor_halted = 1'b0;
    logic [L-1:0] chain, chain_preset = '0, img, exp_rsp;
    logic chain_load = 1'b0;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    scan_chain_loader #(.CHAIN_LEN(L), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wdata(cmd_wdata), .cmd_run(cmd_run), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .processor_enable(processor_enable), .scan_enable(scan_enable),
        .scan_in(scan_in), .scan_out(scan_out),
        .processor_halted(processor_halted), .halted(halted)
    );
    // core scan chain: bits enter at the top and leave from bit 0
    always_ff @(posedge clk)
        if (chain_load) chain <= chain_preset;
        else if (scan_enable) chain <= {scan_in, chain[L-1:1]};
    assign scan_out = chain[0];
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic issue(input logic [L-1:0] w, input logic run, input logic hlt);
        check("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_wdata = w; cmd_run = run; processor_halted = hlt;
        tick();
        cmd_valid = 1'b0; cmd_wdata = L'($urandom); cmd_run = 1'($urandom); processor_halted = 1'b0;
        check("pause_not_ready", cmd_ready, 0);
        check("halted_cleared", halted, 0);
        check("pause_pe_low", processor_enable, 0);
        check("pause_se_low", scan_enable, 0);
    endtask
    task automatic observe(input logic [L-1:0] w);
        int n = 0, se = 0, pe = 0, bad = 0;
        while (!rsp_valid && n < 80) begin
            se += int'(scan_enable);
            pe += int'(processor_enable);
            bad += int'(!scan_enable && scan_in);
            tick();
            n++;
        end
        check("rsp_latency", n, L + 1);
        check("se_cycles", se, L);
        check("pe_during_load", pe, 0);
        check("scan_in_idle", bad, 0);
        check("se_after", scan_enable, 0);
        check("rsp_rdata", rsp_rdata, img);
        check("chain_image", chain, w);
        exp_rsp = img;
        img = w;
    endtask
    task automatic take_rsp(input int hold);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, exp_rsp);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
        check("rdata_kept", rsp_rdata, exp_rsp);
    endtask
    task automatic load(input logic [L-1:0] w, input logic run, input int hold);
        issue(w, run, 1'b0);
        observe(w);
        take_rsp(hold);
        check("pe_after_rsp", processor_enable, run);
    endtask
    task automatic run_halt(input int k);
        int ens = 0;
        for (int c = 0; c < 40 && processor_enable; c++) begin
            ens++;
            if (ens == k) processor_halted = 1'b1;
            tick();
            processor_halted = 1'b0;
        end
        check("run_cycles", ens, k);
        check("halted_set", halted, 1);
        check("halt_ready", cmd_ready, 1);
        check("halt_pe_low", processor_enable, 0);
    endtask
    initial begin
        logic [L-1:0] w;
        int got_valid;
        repeat (3) tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_pe", processor_enable, 0);
        check("rst_se", scan_enable, 0);
        check("rst_halted", halted, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        rst = 1'b1;
        tick();
        chain_preset = 24'hA5A5A5; chain_load = 1'b1;
        tick();
        chain_load = 1'b0;
        img = 24'hA5A5A5;
        load(24'h123456, 1'b0, 0);
        load(24'h000FFF, 1'b0, 5);
        load(L'($urandom), 1'b1, 0);
        run_halt(10);
        for (int i = 0; i < 6; i++) begin
            load(L'($urandom), 1'b0, $urandom_range(0, 3));
            load(L'($urandom), 1'b1, $urandom_range(0, 2));
            run_halt($urandom_range(1, 15));
        end
        // reset during shift cycle 7: eight bits have moved when the abort lands
        w = L'($urandom);
        issue(w, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !scan_enable; i++) tick();
        check("shift_started", scan_enable, 1);
        repeat (7) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_se", scan_enable, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_valid", rsp_valid, 0);
        check("abort_rdata", rsp_rdata, 0);
        img = (img >> 8) | (w << (L - 8));
        got_valid = 0;
        for (int i = 0; i < 30; i++) begin
            got_valid += int'(rsp_valid);
            tick();
        end
        check("abort_no_rsp", got_valid, 0);
        load(L'($urandom), 1'b0, 1);
        load(L'($urandom), 1'b1, 0);
        w = L'($urandom);
        issue(w, 1'b0, 1'b1);
        observe(w);
        take_rsp(2);
        check("cmd_wins_halted", halted, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
